// File: rtl/manchester_pkg.sv
// -----------------------------------------------------------------------------
// manchester_pkg
// Shared definitions for the Manchester transmitter:
//   - tx_state_e            : FSM state encoding (IDLE=0, PREAMBLE=1, DATA=2)
//   - HALF_PERIOD_DEFAULT   : clocks per half-bit (3 -> 6-clock bit)
//   - PREAMBLE_BITS_DEFAULT : preamble length in bits
//   - MANCH_POLARITY        : IEEE 802.3 polarity (first half = ~bit)
//   - encode_half()         : line level for a bit in a given half
// -----------------------------------------------------------------------------
package manchester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } tx_state_e;

    localparam int unsigned HALF_PERIOD_DEFAULT   = 3;
    localparam int unsigned PREAMBLE_BITS_DEFAULT = 8;

    // IEEE 802.3: the first half carries the complement of the bit, so a 1
    // is a low->high transition at mid-bit.
    localparam logic MANCH_POLARITY = 1'b1;

    function automatic logic encode_half(input logic bit_val, input logic second_half);
        return second_half ? bit_val : (bit_val ^ MANCH_POLARITY);
    endfunction

endpackage

// File: rtl/manchester_half_timer.sv
// -----------------------------------------------------------------------------
// manchester_half_timer
// Half-bit timer: a 4-bit counter running 0..HALF_PERIOD-1 while 'run' is
// high, plus a flag telling which half of the bit is on the wire.
// Ports:
//   clock       in  rising-edge clock
//   reset       in  asynchronous active-high reset
//   run         in  transmitter is driving preamble/data half-bits
//   half_tick   out last clock of the current half-bit
//   second_half out current half-bit is the second half of its bit
// -----------------------------------------------------------------------------
module manchester_half_timer
    import manchester_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic half_tick,
    output logic second_half
);

    localparam logic [3:0] LAST_COUNT = 4'(HALF_PERIOD - 1);

    logic [3:0] count_q, count_d;
    logic       second_half_q, second_half_d;

    assign half_tick   = run && (count_q == LAST_COUNT);
    assign second_half = second_half_q;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        count_d       = count_q;
        second_half_d = second_half_q;
        if (!run) begin
            // Idle: park at the start of a first half so the next frame
            // begins with a full-length half-bit.
            count_d       = 4'd0;
            second_half_d = 1'b0;
        end else if (half_tick) begin
            count_d       = 4'd0;
            second_half_d = ~second_half_q;
        end else begin
            count_d = count_q + 4'd1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q       <= 4'd0;
            second_half_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            second_half_q <= second_half_d;
        end
    end

endmodule

// File: rtl/manchester_transmitter.sv
// -----------------------------------------------------------------------------
// manchester_transmitter
// Byte-wide IEEE 802.3 Manchester transmitter, MSB first, with an optional
// alternating 1,0,1,0... preamble sent when a frame starts from idle.
// Build option: define MANCHESTER_TX_PREAMBLE_EN to include the preamble;
// without it an idle handshake goes straight to data.
// Ports:
//   clock          in  rising-edge clock
//   reset          in  asynchronous active-high reset
//   data_in[7:0]   in  byte to transmit
//   data_valid     in  data_in is valid
//   data_ready     out byte accepted this cycle (idle, or last clock of bit 0)
//   manchester_out out registered line output
//   busy           out registered, high while preamble/data is on the wire
// -----------------------------------------------------------------------------
module manchester_transmitter
    import manchester_pkg::*;
#(
    parameter int unsigned HALF_PERIOD   = HALF_PERIOD_DEFAULT,
    parameter int unsigned PREAMBLE_BITS = PREAMBLE_BITS_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       manchester_out,
    output logic       busy
);

    // Elaboration-time range checks on the parameters.
    if (HALF_PERIOD < 1 || HALF_PERIOD > 15) begin : g_bad_half_period
        $error("manchester_transmitter: HALF_PERIOD must be 1..15");
    end
    if (PREAMBLE_BITS < 1 || PREAMBLE_BITS > 16) begin : g_bad_preamble_bits
        $error("manchester_transmitter: PREAMBLE_BITS must be 1..16");
    end

    tx_state_e  state_q, state_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       out_q, out_d;
    logic       busy_q, busy_d;

    logic half_tick;
    logic second_half;
    logic last_data_clock;
    logic handshake;

    manchester_half_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_half_timer (
        .clock       (clock),
        .reset       (reset),
        .run         (state_q != ST_IDLE),
        .half_tick   (half_tick),
        .second_half (second_half)
    );

`ifdef MANCHESTER_TX_PREAMBLE_EN
    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_BITS - 1);

    // Preamble bits count down from PRE_LAST and alternate starting with 1,
    // so a bit is 1 exactly when its index has the same parity as PRE_LAST.
    function automatic logic preamble_bit(input logic [3:0] idx);
        return ~(PRE_LAST[0] ^ idx[0]);
    endfunction
`endif

    assign last_data_clock = (state_q == ST_DATA) && (bit_idx_q == 4'd0) &&
                             second_half && half_tick;
    assign data_ready      = (state_q == ST_IDLE) || last_data_clock;
    assign handshake       = data_valid && data_ready;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        out_d     = out_q;
        case (state_q)
            ST_IDLE: begin
                out_d = 1'b0;
                if (handshake) begin
                    shift_d = data_in;
`ifdef MANCHESTER_TX_PREAMBLE_EN
                    state_d   = ST_PREAMBLE;
                    bit_idx_d = PRE_LAST;
                    out_d     = encode_half(preamble_bit(PRE_LAST), 1'b0);
`else
                    state_d   = ST_DATA;
                    bit_idx_d = 4'd7;
                    out_d     = encode_half(data_in[7], 1'b0);
`endif
                end
            end
`ifdef MANCHESTER_TX_PREAMBLE_EN
            ST_PREAMBLE: begin
                if (half_tick) begin
                    if (!second_half) begin
                        out_d = encode_half(preamble_bit(bit_idx_q), 1'b1);
                    end else if (bit_idx_q != 4'd0) begin
                        bit_idx_d = bit_idx_q - 4'd1;
                        out_d     = encode_half(preamble_bit(bit_idx_q - 4'd1), 1'b0);
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = 4'd7;
                        out_d     = encode_half(shift_q[7], 1'b0);
                    end
                end
            end
`endif
            ST_DATA: begin
                if (half_tick) begin
                    if (!second_half) begin
                        out_d = encode_half(shift_q[7], 1'b1);
                    end else if (bit_idx_q != 4'd0) begin
                        bit_idx_d = bit_idx_q - 4'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        out_d     = encode_half(shift_q[6], 1'b0);
                    end else if (handshake) begin
                        // Back-to-back byte: no preamble, no gap.
                        bit_idx_d = 4'd7;
                        shift_d   = data_in;
                        out_d     = encode_half(data_in[7], 1'b0);
                    end else begin
                        state_d   = ST_IDLE;
                        bit_idx_d = 4'd0;
                        shift_d   = 8'd0;
                        out_d     = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_idx_d = 4'd0;
                shift_d   = 8'd0;
                out_d     = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: the shift register is cleared on reset as well, so an abandoned
    // frame can never leak its remaining bits into a later frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= 4'd0;
            shift_q   <= 8'd0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
        end
    end

    assign manchester_out = out_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_manchester_transmitter.sv
// -----------------------------------------------------------------------------
// tb_manchester_transmitter
// Self-checking bench for manchester_transmitter. A queue-based model expands
// every accepted byte into its expected per-cycle waveform (line level, busy,
// ready); one compare process checks the main DUT against it each cycle.
// Literal wire patterns pin the model. A second instance with HALF_PERIOD=1
// and PREAMBLE_BITS=1 covers the single-clock half-bit case.
// Works with MANCHESTER_TX_PREAMBLE_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_manchester_transmitter;

    localparam int HP  = 3;
    localparam int PB  = 8;
    localparam int PB1 = 1;
`ifdef MANCHESTER_TX_PREAMBLE_EN
    localparam int PRE_CYC = PB * 2 * HP;
    localparam int N1      = 2 * PB1 + 16;
`else
    localparam int PRE_CYC = 0;
    localparam int N1      = 16;
`endif

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       manchester_out;
    logic       busy;

    logic [7:0] data_in1;
    logic       data_valid1;
    logic       data_ready1;
    logic       manchester_out1;
    logic       busy1;

    int n_checks = 0;
    int n_fail   = 0;

    manchester_transmitter #(
        .HALF_PERIOD   (HP),
        .PREAMBLE_BITS (PB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .manchester_out (manchester_out),
        .busy           (busy)
    );

    manchester_transmitter #(
        .HALF_PERIOD   (1),
        .PREAMBLE_BITS (PB1)
    ) dut1 (
        .clock          (clock),
        .reset          (reset),
        .data_in        (data_in1),
        .data_valid     (data_valid1),
        .data_ready     (data_ready1),
        .manchester_out (manchester_out1),
        .busy           (busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic out;
        logic busy;
        logic ready;
    } exp_t;

    exp_t exp_q[$];

    function automatic void push_bit(input logic v);
        exp_t e;
        e.busy  = 1'b1;
        e.ready = 1'b0;
        e.out   = ~v;
        for (int i = 0; i < HP; i++) exp_q.push_back(e);
        e.out   = v;
        for (int i = 0; i < HP; i++) exp_q.push_back(e);
    endfunction

    function automatic void push_byte(input logic [7:0] b, input bit with_pre);
        exp_t e;
        if (with_pre) begin
            for (int i = 0; i < PRE_CYC / (2 * HP); i++) push_bit((i % 2) == 0);
        end
        for (int i = 7; i >= 0; i--) push_bit(b[i]);
        e = exp_q[exp_q.size() - 1];
        e.ready = 1'b1;
        exp_q[exp_q.size() - 1] = e;
    endfunction

    initial begin : compare
        exp_t cur;
        exp_t idle_e;
        bit   was_idle;
        idle_e.out   = 1'b0;
        idle_e.busy  = 1'b0;
        idle_e.ready = 1'b1;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                cur = idle_e;
            end else begin
                cur = (exp_q.size() > 0) ? exp_q[0] : idle_e;
            end
            check("model_out",   64'(manchester_out), 64'(cur.out));
            check("model_busy",  64'(busy),           64'(cur.busy));
            check("model_ready", 64'(data_ready),     64'(cur.ready));
            if (!reset) begin
                was_idle = (exp_q.size() == 0);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (data_valid && cur.ready) push_byte(data_in, was_idle);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Returns at handshake edge + 1; 'edges' counts clock edges taken.
    task automatic wait_accept(output int edges);
        int n;
        n = 1;
        while (1) begin
            @(negedge clock);
            if (data_valid && data_ready) break;
            n++;
            if (n > 1000) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout at %0t: no data_ready within %0d cycles", $time, n);
                edges = n;
                return;
            end
        end
        @(posedge clock);
        #1;
        edges = n;
    endtask

    task automatic capture(output logic [47:0] pre_v, output logic [47:0] dat_v,
                           output int busy_cnt, output int rdy_cnt, output logic last_rdy);
        pre_v    = '0;
        dat_v    = '0;
        busy_cnt = 0;
        rdy_cnt  = 0;
        last_rdy = 1'b0;
        for (int i = 0; i < PRE_CYC; i++) begin
            @(negedge clock);
            pre_v = {pre_v[46:0], manchester_out};
            busy_cnt += int'(busy);
            rdy_cnt  += int'(data_ready);
        end
        for (int i = 0; i < 48; i++) begin
            @(negedge clock);
            dat_v = {dat_v[46:0], manchester_out};
            busy_cnt += int'(busy);
            rdy_cnt  += int'(data_ready);
            last_rdy = data_ready;
            #1 data_in = 8'($urandom);
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin : stimulus
        logic [47:0] pre_v, dat_v;
        logic [17:0] wire1, rdy1;
        int          edges, busy_cnt, rdy_cnt;
        logic        last_rdy;

        reset       = 1'b1;
        data_in     = 8'h00;
        data_valid  = 1'b0;
        data_in1    = 8'h00;
        data_valid1 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_out",   64'(manchester_out), 64'd0);
        check("reset_busy",  64'(busy),           64'd0);
        check("reset_ready", 64'(data_ready),     64'd1);
        reset = 1'b0;

        // Idle for 20 cycles.
        repeat (20) @(posedge clock);
        #1;
        check("idle_out", 64'(manchester_out), 64'd0);

        // Single byte 0xA5.
        data_valid = 1'b1;
        data_in    = 8'hA5;
        wait_accept(edges);
        data_valid = 1'b0;
        capture(pre_v, dat_v, busy_cnt, rdy_cnt, last_rdy);
`ifdef MANCHESTER_TX_PREAMBLE_EN
        check("a5_preamble", 64'(pre_v), 64'({4{12'b000111_111000}}));
`endif
        check("a5_data", 64'(dat_v),
              64'(48'b000111_111000_000111_111000_111000_000111_111000_000111));
        @(negedge clock);
        busy_cnt += int'(busy);
        check("a5_busy_cycles", 64'(busy_cnt), 64'(PRE_CYC + 48));
        check("a5_idle_out",    64'(manchester_out), 64'd0);
        @(posedge clock);
        #1;

        // 0x00 then 0xFF back to back with data_valid held high.
        data_valid = 1'b1;
        data_in    = 8'h00;
        wait_accept(edges);
        check("b2b_first_edges", 64'(edges), 64'd1);
        data_in = 8'hFF;
        wait_accept(edges);
        check("b2b_second_edges", 64'(edges), 64'(PRE_CYC + 48));
        data_valid = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clock);
            dat_v = {dat_v[46:0], manchester_out};
        end
        check("b2b_ff_data", 64'(dat_v), 64'({8{6'b000111}}));
        repeat (3) @(posedge clock);
        #1;

        // Asynchronous reset in the third data bit of 0x20.
        data_valid = 1'b1;
        data_in    = 8'h20;
        wait_accept(edges);
        data_valid = 1'b0;
        data_in    = 8'h00;
        repeat (PRE_CYC + 15) @(posedge clock);
        #2;
        check("rst_pre_out", 64'(manchester_out), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_async_out",   64'(manchester_out), 64'd0);
        check("rst_async_busy",  64'(busy),           64'd0);
        check("rst_async_ready", 64'(data_ready),     64'd1);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        data_valid = 1'b1;
        data_in    = 8'h3C;
        wait_accept(edges);
        data_valid = 1'b0;
        capture(pre_v, dat_v, busy_cnt, rdy_cnt, last_rdy);
`ifdef MANCHESTER_TX_PREAMBLE_EN
        check("3c_preamble", 64'(pre_v), 64'({4{12'b000111_111000}}));
`endif
        check("3c_data", 64'(dat_v),
              64'(48'b111000_111000_000111_000111_000111_000111_111000_111000));
        repeat (3) @(posedge clock);
        #1;

        // 0x5A while data_in is scrambled every cycle.
        data_valid = 1'b1;
        data_in    = 8'h5A;
        wait_accept(edges);
        data_valid = 1'b0;
        capture(pre_v, dat_v, busy_cnt, rdy_cnt, last_rdy);
        check("5a_data", 64'(dat_v),
              64'(48'b111000_000111_111000_000111_000111_111000_000111_111000));
        check("5a_ready_count", 64'(rdy_cnt),  64'd1);
        check("5a_ready_last",  64'(last_rdy), 64'd1);
        data_in = 8'h00;
        repeat (3) @(posedge clock);
        #1;

        // HALF_PERIOD=1 instance, byte 0x80.
        check("hp1_idle_ready", 64'(data_ready1), 64'd1);
        data_valid1 = 1'b1;
        data_in1    = 8'h80;
        @(posedge clock);
        #1;
        data_valid1 = 1'b0;
        data_in1    = 8'h00;
        wire1 = '0;
        rdy1  = '0;
        for (int i = 0; i < N1; i++) begin
            @(negedge clock);
            wire1 = {wire1[16:0], manchester_out1};
            rdy1  = {rdy1[16:0], data_ready1};
        end
`ifdef MANCHESTER_TX_PREAMBLE_EN
        check("hp1_wire", 64'(wire1), 64'(18'b01_01_10101010101010));
`else
        check("hp1_wire", 64'(wire1), 64'(18'b01_10101010101010));
`endif
        check("hp1_ready", 64'(rdy1), 64'd1);
        @(negedge clock);
        check("hp1_idle_busy", 64'(busy1),           64'd0);
        check("hp1_idle_out",  64'(manchester_out1), 64'd0);

        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
